// File: rtl/game_pkg.sv
// Shared types and constants for the per-frame game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_PLAY,
        ST_DYING,
        ST_CLEAR,
        ST_GAMEOVER
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        GHOST_BLINKY = 2'd0,
        GHOST_PINKY  = 2'd1,
        GHOST_INKY   = 2'd2,
        GHOST_CLYDE  = 2'd3
    } ghost_idx_t;

    localparam int NUM_GHOSTS     = 4;
    localparam int PTS_PELLET     = 10;
    localparam int PTS_POWER      = 50;
    localparam int PTS_GHOST_BASE = 200;
    localparam int PTS_GHOST_MAX  = 1600;

    // 17-bit sum clamped to the 16-bit score range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [11:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/ghost_hit_detect.sv
// Combinational sprite overlap test: |dx| and |dy| both strictly below HIT_DIST.
module ghost_hit_detect #(
    parameter int HIT_DIST = 8
) (
    input  logic [9:0] pac_x,
    input  logic [9:0] pac_y,
    input  logic [9:0] ghost_x,
    input  logic [9:0] ghost_y,
    output logic       hit
);

    localparam logic [10:0] HIT_W = 11'(HIT_DIST);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] adx;
    logic [10:0] ady;

    // One extra bit keeps the difference signed so the screen edges never wrap.
    always_comb begin
        dx  = {1'b0, pac_x} - {1'b0, ghost_x};
        dy  = {1'b0, pac_y} - {1'b0, ghost_y};
        adx = dx[10] ? (~dx + 11'd1) : dx;
        ady = dy[10] ? (~dy + 11'd1) : dy;
        hit = (adx < HIT_W) && (ady < HIT_W);
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Per-frame game sequencer: lives, score, pellets, fright mode, collisions and
// the freeze / death-animation controls fed to the motion and colour logic.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int HIT_DIST      = 8,
    parameter int READY_FRAMES  = 120,
    parameter int DEATH_FRAMES  = 48,
    parameter int CLEAR_FRAMES  = 90,
    parameter int FRIGHT_FRAMES = 360,
    parameter int PELLET_TOTAL  = 244,
    parameter int LIVES_INIT    = 3
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    input  logic                        start,
    input  logic [9:0]                  pac_x,
    input  logic [9:0]                  pac_y,
    input  logic [NUM_GHOSTS-1:0][9:0]  ghost_x,
    input  logic [NUM_GHOSTS-1:0][9:0]  ghost_y,
    input  logic                        pellet_eaten,
    input  logic                        power_eaten,
    output logic                        lose_game,
    output logic                        freeze,
    output logic                        respawn,
    output logic                        pellet_reset,
    output logic                        frightened,
    output logic [NUM_GHOSTS-1:0]       ghost_eaten,
    output logic [NUM_GHOSTS-1:0]       eaten_mask,
    output logic [15:0]                 score,
    output logic [1:0]                  lives,
    output logic                        level_clear,
    output logic                        game_over
);

    localparam int TMR_MAX = (READY_FRAMES > CLEAR_FRAMES)
                           ? ((READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES)
                           : ((CLEAR_FRAMES > DEATH_FRAMES) ? CLEAR_FRAMES : DEATH_FRAMES);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int FR_W  = $clog2(FRIGHT_FRAMES + 1);
    localparam int PL_W  = $clog2(PELLET_TOTAL + 1);

    game_state_t              state_reg;
    game_state_t              state_next;
    logic [TMR_W-1:0]         phase_cnt_reg;
    logic [FR_W-1:0]          fright_cnt_reg;
    logic [FR_W-1:0]          fright_cnt_next;
    logic [PL_W-1:0]          pellets_left_reg;
    logic [PL_W-1:0]          pellets_left_next;
    logic [NUM_GHOSTS-1:0]    eaten_mask_reg;
    logic [NUM_GHOSTS-1:0]    eaten_mask_next;
    logic [NUM_GHOSTS-1:0]    ghost_eaten_reg;
    logic [10:0]              chain_reg;
    logic [10:0]              chain_next;
    logic [15:0]              score_reg;
    logic [11:0]              score_add;
    logic [1:0]               lives_reg;
    logic                     respawn_reg;
    logic                     pellet_reset_reg;

    logic [NUM_GHOSTS-1:0]    hit;
    logic [NUM_GHOSTS-1:0]    unmasked_hit;
    logic [NUM_GHOSTS-1:0]    lower_hit;
    logic [NUM_GHOSTS-1:0]    eat_sel;
    logic                     in_play;
    logic                     fright_active;
    logic                     death_hit;
    logic                     pellet_go;
    logic                     power_go;
    logic                     timer_last;

    assign in_play       = (state_reg == ST_PLAY);
    assign fright_active = (fright_cnt_reg != '0);

    // Only the lowest-index unmasked ghost under pacman is eaten in a given frame.
    assign lower_hit[0] = 1'b0;
    for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
        ghost_hit_detect #(
            .HIT_DIST (HIT_DIST)
        ) u_hit (
            .pac_x   (pac_x),
            .pac_y   (pac_y),
            .ghost_x (ghost_x[gi]),
            .ghost_y (ghost_y[gi]),
            .hit     (hit[gi])
        );
        assign unmasked_hit[gi] = hit[gi] & ~eaten_mask_reg[gi];
        assign eat_sel[gi]      = in_play & fright_active & unmasked_hit[gi] & ~lower_hit[gi];
        if (gi < NUM_GHOSTS - 1) begin : g_chain
            assign lower_hit[gi+1] = lower_hit[gi] | unmasked_hit[gi];
        end
    end

    assign death_hit = in_play & ~fright_active & (|unmasked_hit);

    always_comb begin
        timer_last = 1'b0;
        case (state_reg)
            ST_READY: timer_last = (phase_cnt_reg == TMR_W'(READY_FRAMES - 1));
            ST_DYING: timer_last = (phase_cnt_reg == TMR_W'(DEATH_FRAMES - 1));
            ST_CLEAR: timer_last = (phase_cnt_reg == TMR_W'(CLEAR_FRAMES - 1));
            default:  timer_last = 1'b0;
        endcase
    end

    // A death in the same frame swallows any pellet events.
    always_comb begin
        pellet_go = in_play & ~death_hit & pellet_eaten;
        power_go  = in_play & ~death_hit & power_eaten;

        pellets_left_next = pellets_left_reg;
        if (pellet_go && pellets_left_next != '0)
            pellets_left_next = pellets_left_next - PL_W'(1);
        if (power_go && pellets_left_next != '0)
            pellets_left_next = pellets_left_next - PL_W'(1);

        score_add = '0;
        if (pellet_go)
            score_add = score_add + 12'(PTS_PELLET);
        if (power_go)
            score_add = score_add + 12'(PTS_POWER);
        if (|eat_sel)
            score_add = score_add + {1'b0, chain_reg};

        if (power_go)
            fright_cnt_next = FR_W'(FRIGHT_FRAMES);
        else if (fright_active)
            fright_cnt_next = fright_cnt_reg - FR_W'(1);
        else
            fright_cnt_next = fright_cnt_reg;

        eaten_mask_next = eaten_mask_reg | eat_sel;
        if (fright_cnt_reg == FR_W'(1) || power_go)
            eaten_mask_next = '0;

        chain_next = chain_reg;
        if (|eat_sel)
            chain_next = (chain_reg >= 11'(PTS_GHOST_MAX / 2)) ? 11'(PTS_GHOST_MAX)
                                                               : {chain_reg[9:0], 1'b0};
        if (power_go)
            chain_next = 11'(PTS_GHOST_BASE);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_GAMEOVER: if (start) state_next = ST_READY;
            ST_READY:             if (timer_last) state_next = ST_PLAY;
            ST_PLAY: begin
                if (death_hit)
                    state_next = ST_DYING;
                else if (pellets_left_next == '0)
                    state_next = ST_CLEAR;
            end
            ST_DYING: begin
                if (timer_last)
                    state_next = (lives_reg == 2'd1) ? ST_GAMEOVER : ST_READY;
            end
            ST_CLEAR:             if (timer_last) state_next = ST_READY;
            default:              state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        freeze      = 1'b1;
        lose_game   = 1'b0;
        level_clear = 1'b0;
        game_over   = 1'b0;
        case (state_reg)
            ST_PLAY:     freeze = 1'b0;
            ST_DYING:    lose_game = 1'b1;
            ST_CLEAR:    level_clear = 1'b1;
            ST_GAMEOVER: begin
                lose_game = 1'b1;
                game_over = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        respawn_reg      <= 1'b0;
        pellet_reset_reg <= 1'b0;
        ghost_eaten_reg  <= '0;
        if (Reset) begin
            phase_cnt_reg    <= '0;
            fright_cnt_reg   <= '0;
            pellets_left_reg <= PL_W'(PELLET_TOTAL);
            eaten_mask_reg   <= '0;
            chain_reg        <= 11'(PTS_GHOST_BASE);
            score_reg        <= '0;
            lives_reg        <= 2'(LIVES_INIT);
        end else begin
            case (state_reg)
                ST_IDLE, ST_GAMEOVER: begin
                    if (start) begin
                        phase_cnt_reg    <= '0;
                        fright_cnt_reg   <= '0;
                        pellets_left_reg <= PL_W'(PELLET_TOTAL);
                        eaten_mask_reg   <= '0;
                        chain_reg        <= 11'(PTS_GHOST_BASE);
                        score_reg        <= '0;
                        lives_reg        <= 2'(LIVES_INIT);
                        respawn_reg      <= 1'b1;
                        pellet_reset_reg <= 1'b1;
                    end
                end
                ST_READY: begin
                    phase_cnt_reg <= timer_last ? '0 : phase_cnt_reg + TMR_W'(1);
                end
                ST_PLAY: begin
                    phase_cnt_reg <= '0;
                    if (death_hit) begin
                        fright_cnt_reg <= '0;
                        eaten_mask_reg <= '0;
                    end else begin
                        score_reg        <= sat_add16(score_reg, score_add);
                        pellets_left_reg <= pellets_left_next;
                        fright_cnt_reg   <= fright_cnt_next;
                        eaten_mask_reg   <= eaten_mask_next;
                        chain_reg        <= chain_next;
                        ghost_eaten_reg  <= eat_sel;
                    end
                end
                ST_DYING: begin
                    phase_cnt_reg  <= timer_last ? '0 : phase_cnt_reg + TMR_W'(1);
                    fright_cnt_reg <= '0;
                    if (timer_last) begin
                        lives_reg   <= lives_reg - 2'd1;
                        respawn_reg <= (lives_reg != 2'd1);
                    end
                end
                ST_CLEAR: begin
                    phase_cnt_reg <= timer_last ? '0 : phase_cnt_reg + TMR_W'(1);
                    if (timer_last) begin
                        pellets_left_reg <= PL_W'(PELLET_TOTAL);
                        fright_cnt_reg   <= '0;
                        eaten_mask_reg   <= '0;
                        respawn_reg      <= 1'b1;
                        pellet_reset_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign respawn      = respawn_reg;
    assign pellet_reset = pellet_reset_reg;
    assign frightened   = fright_active;
    assign ghost_eaten  = ghost_eaten_reg;
    assign eaten_mask   = eaten_mask_reg;
    assign score        = score_reg;
    assign lives        = lives_reg;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Per-frame game sequencer upstream of the colour mapper. It owns the lose_game flag that drives the pacman death animation. It also tracks lives, score, remaining pellets and power-pellet (frightened) mode, detects pacman/ghost collisions from sprite positions, and freezes the motion logic during ready, death and level-clear intervals. All logic advances once per frame_clk edge.

Parameters:
HIT_DIST, 8, collision when both |dx| and |dy| are strictly less than this value (pixels)
READY_FRAMES, 120, frozen frames before play begins
DEATH_FRAMES, 48, frames lose_game is held before respawn; must be ≥ 12 so the death animation completes
CLEAR_FRAMES, 90, frozen frames after the last pellet
FRIGHT_FRAMES, 360, frightened-mode duration
PELLET_TOTAL, 244, pellets plus power pellets per level
LIVES_INIT, 3, lives at game start (1..3)

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  synchronous, active-high
start  in  1  level; begins a game from IDLE or GAMEOVER
pac_x, pac_y  in  10 each  pacman top-left position
ghost_x, ghost_y  in  4x10 each  ghost positions; index 0..3 = blinky, pinky, inky, clyde
pellet_eaten  in  1  one-frame pulse
power_eaten  in  1  one-frame pulse
lose_game  out  1  death animation or game over active
freeze  out  1  hold pacman and ghost motion
respawn  out  1  one-frame pulse; return sprites to home positions
pellet_reset  out  1  one-frame pulse; reload maze pellets
frightened  out  1  frightened mode active
ghost_eaten  out  4  one-frame pulse per eaten ghost
eaten_mask  out  4  ghosts already eaten in the current fright period
score  out  16  binary, saturates at 16'hFFFF
lives  out  2  remaining lives
level_clear  out  1  high during the CLEAR state
game_over  out  1  high in GAMEOVER

Behaviour:
- All outputs are registered. A response appears on the first frame_clk edge after inputs are sampled (1-frame latency).
- Reset state: IDLE. Output values: freeze=1; lose_game=0; all pulses 0; frightened=0; eaten_mask=0; score=0; lives=LIVES_INIT; level_clear=0; game_over=0. Internal pellets_left=PELLET_TOTAL. Reset overrides every state, including mid-death.
- State IDLE: freeze=1. If start=1, go to READY, load score=0, lives=LIVES_INIT, pellets_left=PELLET_TOTAL, pulse pellet_reset and respawn.
- State READY: freeze=1. A counter runs from 0 to READY_FRAMES-1, then the state goes to PLAY.
- State PLAY: freeze=0.
  - pellet_eaten adds 10 and decrements pellets_left.
  - power_eaten adds 50, decrements pellets_left, loads fright_cnt=FRIGHT_FRAMES, clears eaten_mask and resets chain to 200.
  - frightened = (fright_cnt != 0). fright_cnt decrements each PLAY frame; eaten_mask clears when it reaches 0.
- Collision (any state, only acted on in PLAY): computed per ghost from 11-bit differences with absolute value, no wrap.
  - Hit on a ghost that is not masked while frightened: the lowest-index such ghost only is scored this frame. It gets a ghost_eaten pulse, its mask bit is set, chain is added to score, then chain doubles (200, 400, 800, 1600; max 1600).
  - Hit on a ghost that is not masked while not frightened: go to DYING. This takes priority over pellet and clear events in the same frame; those pellet events are ignored.
  - Hits on masked ghosts are ignored.
- Clear: pellets_left reaches 0 with no death that frame → CLEAR.
- State DYING: lose_game=1, freeze=1, fright_cnt=0. After DEATH_FRAMES frames, lives decrements. If the pre-decrement value was 1, go to GAMEOVER (lives=0); otherwise pulse respawn and go to READY.
- State CLEAR: level_clear=1, freeze=1. After CLEAR_FRAMES frames, pulse pellet_reset and respawn, reload pellets_left, go to READY. Score and lives are kept.
- State GAMEOVER: lose_game=1, game_over=1, freeze=1. start=1 behaves as in IDLE.
- Score addition is 17-bit, clamped to 16'hFFFF.
- pellets_left never underflows; decrements at 0 are ignored.
- Pulse inputs outside PLAY are ignored.

Decomposition:
- game_pkg holds: the state enum (IDLE, READY, PLAY, DYING, CLEAR, GAMEOVER); the direction encoding (0 up, 1 left, 2 down, 3 right); ghost index constants; the score constants PTS_PELLET=10, PTS_POWER=50, PTS_GHOST_BASE=200.
- One sub-module, ghost_hit_detect: combinational |dx|/|dy| < HIT_DIST comparator, instantiated four times.

Test Plan:
- Reset, hold start=0 for 10 frames → freeze=1, lives=3, score=0, lose_game=0. Pulse start → pellet_reset=1 and respawn=1 for one frame; freeze falls after 120 further frames.
- In PLAY, pulse pellet_eaten three times and power_eaten once → score=80, pellets_left=240, frightened=1 for exactly 360 frames.
- While frightened, overlap ghosts 1 and 2 on pacman simultaneously → ghost_eaten=0010 then 0100 on consecutive frames, score +200 then +400. Hold the overlap → no further scoring.
- Not frightened, ghost 0 at pac_x+7 → DYING, lose_game=1 for 48 frames, then respawn pulse, lives=2. With ghost 0 at pac_x+8 → no death.
- With lives=1, cause a collision → after 48 frames lives=0, game_over=1, lose_game stays 1. start → score=0, lives=3, READY.
- pellets_left=1: pellet_eaten and a collision in the same frame → DYING, no CLEAR, score unchanged. Repeat without the collision → CLEAR for 90 frames, then pellet_reset, pellets_left=244.
